bcd_seg7_scan_driver: RTL

//  Downstream consumer of the 8-bit binary-to-BCD converter. Latches a 3-digit BCD value
//  (hundreds/tens/ones) and drives a time-multiplexed 3-digit common-anode 7-segment display.

---
 rtl/bcd_seg7_scan_driver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/bcd_seg7_scan_driver.sv
// Three-digit common-anode 7-segment scan driver fed by a BCD converter.
// One digit is lit at a time, and each slot opens with a short all-dark guard
// so that the previous digit does not ghost into the next one. Leading zeros
// can be blanked. New values are held in a shadow register and only reach
// the display at a frame boundary, so a frame never shows a mix of old and
// new digits.
module bcd_seg7_scan_driver #(
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD         = 2,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_H = 2'd0,
    S_T = 2'd1,
    S_O = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_slot_end;
  logic          w_frame_wrap;

  // Digits are packed as {hundreds, tens, ones}.
  logic [11:0]   r_active;
  logic [11:0]   w_active_next;
  logic [11:0]   r_shadow;
  logic          r_pending;
  logic          w_pending_next;

  logic [6:0]    r_seg;
  logic [6:0]    w_seg_next;
  logic [2:0]    r_an;
  logic [2:0]    w_an_next;
  logic          r_frame_done;
  logic [3:0]    w_digit;
  logic [2:0]    w_slot_an;
  logic          w_blank;

  // Active-low segment pattern {g,f,e,d,c,b,a}; a non-BCD nibble shows a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h40;
      4'd1:    f_decode = 7'h79;
      4'd2:    f_decode = 7'h24;
      4'd3:    f_decode = 7'h30;
      4'd4:    f_decode = 7'h19;
      4'd5:    f_decode = 7'h12;
      4'd6:    f_decode = 7'h02;
      4'd7:    f_decode = 7'h78;
      4'd8:    f_decode = 7'h00;
      4'd9:    f_decode = 7'h10;
      default: f_decode = 7'h3F;
    endcase
  endfunction

  // Next scan position, and the commit of the shadow value at the frame wrap.
  always_comb begin
    w_slot_end     = (r_cnt == CNT_LAST);
    w_frame_wrap   = w_slot_end && (r_state == S_O);
    w_cnt_next     = w_slot_end ? '0 : r_cnt + CW'(1);
    w_state_next   = r_state;
    w_active_next  = r_active;
    w_pending_next = r_pending;
    if (w_slot_end) begin
      case (r_state)
        S_H:     w_state_next = S_T;
        S_T:     w_state_next = S_O;
        default: w_state_next = S_H;
      endcase
    end
    if (w_frame_wrap) begin
      // A load landing on the wrap edge goes straight to the display.
      if (load) begin
        w_active_next = {hundreds, tens, ones};
      end else if (r_pending) begin
        w_active_next = r_shadow;
      end
      w_pending_next = 1'b0;
    end else if (load) begin
      w_pending_next = 1'b1;
    end
  end

  // Output pattern for the upcoming cycle, derived from the next state so
  // that the registered outputs line up exactly with the slot boundaries.
  always_comb begin
    w_an_next  = 3'b111;
    w_seg_next = 7'h7F;
    case (w_state_next)
      S_H: begin
        w_digit   = w_active_next[11:8];
        w_slot_an = 3'b011;
        w_blank   = BLANK_LEADING && (w_active_next[11:8] == 4'd0);
      end
      S_T: begin
        w_digit   = w_active_next[7:4];
        w_slot_an = 3'b101;
        w_blank   = BLANK_LEADING && (w_active_next[11:8] == 4'd0)
                                  && (w_active_next[7:4] == 4'd0);
      end
      default: begin
        w_digit   = w_active_next[3:0];
        w_slot_an = 3'b110;
        w_blank   = 1'b0;
      end
    endcase
    if ((int'(w_cnt_next) >= GUARD) && !w_blank) begin
      w_an_next  = w_slot_an;
      w_seg_next = f_decode(w_digit);
    end
  end

  // Scan FSM state and slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_H;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Shadow capture, pending flag and displayed digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (load) begin
        r_shadow <= {hundreds, tens, ones};
      end
      r_active  <= w_active_next;
      r_pending <= w_pending_next;
    end
  end

  // Registered display outputs and end-of-frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= 7'h7F;
      r_an         <= 3'b111;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_an         <= w_an_next;
      r_frame_done <= w_frame_wrap;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
